// File: rtl/neuron_mac_accum.sv
// neuron_mac_accum: sums N_INPUTS signed products plus a per-neuron bias, then
// scales (arithmetic right shift), saturates and offers one result per frame
// over a valid/ready handshake.
// Optional build macro NEURON_RELU_EN: clamps negative results to zero after
// saturation. out_sat still reports the pre-ReLU condition.
//
// state | meaning
// ------+-----------------------------------------------------------
// ACC   | accepting product beats, accumulating the current frame
// HOLD  | frame result presented, waiting for downstream to take it

module neuron_mac_accum #(
    parameter int PROD_W   = 8,
    parameter int ACC_W    = 16,
    parameter int OUT_W    = 8,
    parameter int N_INPUTS = 4,
    parameter int SHIFT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic [ACC_W-1:0]  bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    // Bitwise inversion of the positive limit gives the negative limit.
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {
        ST_ACC,
        ST_HOLD
    } state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;
    logic                     out_sat_q, out_sat_d;

    logic                     beat;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  add_a;
    logic signed [ACC_W-1:0]  sum;
    logic                     add_ovf;
    logic                     ovf_frame;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [ACC_W-1:0]  clamped;
    logic                     sat_hit;

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    // Datapath: accumulate, detect overflow, scale and saturate the running sum.
    always_comb begin
        beat     = in_valid && (state_q == ST_ACC);
        prod_ext = ACC_W'($signed(in_prod));
        // The first beat of a frame starts from the bias instead of the old sum.
        add_a    = (cnt_q == '0) ? $signed(bias) : acc_q;
        sum      = add_a + prod_ext;
        add_ovf  = (add_a[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != add_a[ACC_W-1]);
        ovf_frame = add_ovf | ((cnt_q != '0) & ovf_q);
        shifted  = sum >>> SHIFT;
        clamped  = shifted;
        sat_hit  = 1'b0;
        if (shifted > SAT_MAX) begin
            clamped = SAT_MAX;
            sat_hit = 1'b1;
        end else if (shifted < SAT_MIN) begin
            clamped = SAT_MIN;
            sat_hit = 1'b1;
        end
`ifdef NEURON_RELU_EN
        if (clamped[ACC_W-1]) begin
            clamped = '0;
        end
`endif
    end

    // Next-state and register updates for the ACC/HOLD handshake FSM.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            ST_ACC: begin
                if (beat) begin
                    acc_d = sum;
                    ovf_d = ovf_frame;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d      = '0;
                        state_d    = ST_HOLD;
                        out_data_d = OUT_W'(clamped);
                        out_sat_d  = ovf_frame | sat_hit;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_neuron_mac_accum.sv
// Bench for neuron_mac_accum: two instances (SHIFT=0 and SHIFT=2) share the
// same stimulus; each has its own expected-result queue popped on handshake.
module tb_neuron_mac_accum;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_prod;
    logic [15:0] bias;

    logic       in_ready0, out_valid0, out_sat0;
    logic [7:0] out_data0;
    logic       in_ready2, out_valid2, out_sat2;
    logic [7:0] out_data2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] exp_q0[$];
    logic [8:0] exp_q2[$];
    logic [8:0] e0, e2;

    always #5 clk = ~clk;

    neuron_mac_accum #(.PROD_W(8), .ACC_W(16), .OUT_W(8), .N_INPUTS(4), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_prod(in_prod), .bias(bias), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_sat(out_sat0)
    );

    neuron_mac_accum #(.PROD_W(8), .ACC_W(16), .OUT_W(8), .N_INPUTS(4), .SHIFT(2)) dut_s2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_prod(in_prod), .bias(bias), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .out_sat(out_sat2)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: 16-bit wrapping accumulation, floor shift, saturation.
    function automatic logic [8:0] model(input int b, input int p[4], input int sh);
        int acc, t, v;
        logic ovf, s;
        logic signed [15:0] w;
        logic [7:0] d;
        acc = b;
        ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t   = acc + p[i];
            w   = t[15:0];
            ovf = ovf | (int'(w) != t);
            acc = int'(w);
        end
        v = acc >>> sh;
        s = 1'b0;
        if (v > 127) begin
            v = 127;
            s = 1'b1;
        end else if (v < -128) begin
            v = -128;
            s = 1'b1;
        end
`ifdef NEURON_RELU_EN
        if (v < 0) v = 0;
`endif
        d = v[7:0];
        return {ovf | s, d};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid0 && out_ready) begin
            if (exp_q0.size() == 0) begin
                check("unexpected_result0", 1, 0);
            end else begin
                e0 = exp_q0.pop_front();
                check("data0", $signed(out_data0), $signed(e0[7:0]));
                check("sat0", int'(out_sat0), int'(e0[8]));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid2 && out_ready) begin
            if (exp_q2.size() == 0) begin
                check("unexpected_result2", 1, 0);
            end else begin
                e2 = exp_q2.pop_front();
                check("data2", $signed(out_data2), $signed(e2[7:0]));
                check("sat2", int'(out_sat2), int'(e2[8]));
            end
        end
    end

    // All tasks run from posedge+#1 and return at posedge+#1.
    task automatic wait_ready();
        int k = 0;
        while (!in_ready0 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready0) check("ready_timeout", 0, 1);
    endtask

    task automatic send_frame(input int b, input int p[4], input int max_bub);
        exp_q0.push_back(model(b, p, 0));
        exp_q2.push_back(model(b, p, 2));
        wait_ready();
        bias = b[15:0];
        for (int i = 0; i < 4; i++) begin
            if (max_bub > 0) begin
                repeat ($urandom_range(max_bub, 0)) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            wait_ready();
            check("pre_last_valid", int'(out_valid0), 0);
            in_valid = 1'b1;
            in_prod  = p[i][7:0];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("latency_valid", int'(out_valid0), 1);
        check("latency_ready", int'(in_ready0), 0);
    endtask

    initial begin
        int rp[4];
        int rb;
        rst = 1'b1; in_valid = 1'b0; in_prod = '0; bias = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready0), 1);
        check("rst_out_valid", int'(out_valid0), 0);
        check("rst_out_data", int'(out_data0), 0);
        check("rst_out_sat", int'(out_sat0), 0);
        check("rst_out_valid2", int'(out_valid2), 0);
        rst = 1'b0;

        send_frame(5, '{3, -2, 7, 1}, 0);
        send_frame(0, '{100, 100, 100, 0}, 0);
        send_frame(0, '{-64, -64, -64, -64}, 0);
        send_frame(32767, '{1, 0, 0, 0}, 0);

        // Backpressure: result must hold while beats are offered.
        wait_ready();
        out_ready = 1'b0;
        send_frame(0, '{1, 2, 3, 4}, 0);
        repeat (5) begin
            in_valid = 1'b1;
            in_prod  = 8'd50;
            @(posedge clk); #1;
            check("bp_in_ready", int'(in_ready0), 0);
            check("bp_out_valid", int'(out_valid0), 1);
            check("bp_out_data", $signed(out_data0), 10);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_released", int'(out_valid0), 0);
        send_frame(0, '{1, 1, 1, 1}, 0);

        // Reset after two accepted beats discards the partial frame.
        wait_ready();
        in_valid = 1'b1;
        in_prod  = 8'd10;
        bias     = '0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out_valid", int'(out_valid0), 0);
        check("mid_rst_out_data", int'(out_data0), 0);
        check("mid_rst_out_sat", int'(out_sat0), 0);
        check("mid_rst_in_ready", int'(in_ready0), 1);
        check("mid_rst_out_data2", int'(out_data2), 0);
        rst = 1'b0;
        send_frame(0, '{1, 2, 3, 4}, 0);

        // Bubbles, and the floor-shift cases on the SHIFT=2 instance.
        send_frame(5, '{3, -2, 7, 1}, 3);
        send_frame(-3, '{-4, -2, -1, -3}, 3);
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 4; i++) rp[i] = int'($urandom_range(255, 0)) - 128;
            rb = int'($urandom_range(4000, 0)) - 2000;
            send_frame(rb, rp, 2);
        end

        begin
            int k = 0;
            while ((exp_q0.size() != 0 || exp_q2.size() != 0) && k < 100) begin
                @(posedge clk); #1;
                k++;
            end
        end
        check("drain0", exp_q0.size(), 0);
        check("drain2", exp_q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
